// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and select helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // Callers zero-extend their select vector to MAX_SLAVES bits.
  function automatic logic onehot_valid(input logic [MAX_SLAVES-1:0] v);
    return (v != '0) && ((v & (v - MAX_SLAVES'(1))) == '0);
  endfunction

  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_resp_mux_n_if.sv
// Decoder/slave/master signal bundle around the response mux.
// Handshake: an address phase is accepted on a rising HCLK edge where HREADY=1;
// the data phase it opens completes on the first later edge where HREADY=1 again.
interface ahb_resp_mux_n_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic [NUM_SLAVES-1:0]            HSEL_S;
  logic [1:0]                       HTRANS;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]            HRESP_S;
  logic [NUM_SLAVES-1:0]            HREADYOUT_S;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic                             HREADY;
  logic                             HRESP;
  logic                             DEC_ERR;

  // The mux itself.
  modport slave (
    input  HSEL_S, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    output HRDATA, HREADY, HRESP, DEC_ERR
  );

  // The surrounding decoder, slaves and master.
  modport master (
    output HSEL_S, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    input  HRDATA, HREADY, HRESP, DEC_ERR
  );
endinterface

// File: rtl/ahb_resp_mux_n_default_slave.sv
// Built-in default slave: two-cycle AHB ERROR response for unmapped or
// multi-hot selects, with a one-cycle DEC_ERR pulse in the first error cycle.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic       unmapped,
  input  logic [1:0] htrans,
  output logic       hready,
  output logic       hresp,
  output logic       dec_err,
  output ds_state_t  state
);

  logic start;
  assign start = capture && unmapped && htrans_active(htrans);

  // Outputs are registered alongside the state so they reflect the state entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DS_IDLE;
      hready  <= 1'b1;
      hresp   <= HRESP_OKAY;
      dec_err <= 1'b0;
    end else begin
      dec_err <= 1'b0;
      unique case (state)
        DS_IDLE, DS_ERR2: begin
          if (start) begin
            state   <= DS_ERR1;
            hready  <= 1'b0;
            hresp   <= HRESP_ERROR;
            dec_err <= 1'b1;
          end else begin
            state   <= DS_IDLE;
            hready  <= 1'b1;
            hresp   <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state  <= DS_ERR2;
          hready <= 1'b1;
          hresp  <= HRESP_ERROR;
        end
        default: begin
          state  <= DS_IDLE;
          hready <= 1'b1;
          hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_resp_mux_n.sv
// N-slave AHB-Lite response mux: registers the one-hot select at each accepted
// address phase and routes the chosen slave (or the default slave) to the master.
module ahb_resp_mux_n
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_resp_mux_n_if.slave    bus,
  output ds_state_t          ds_state
);

  logic [NUM_SLAVES-1:0] dsel_q;
  logic                  def_q;
  logic                  capture;
  logic                  unmapped;
  logic                  ds_hready;
  logic                  ds_hresp;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  ready_sel;
  logic                  resp_sel;

  assign capture  = bus.HREADY;
  assign unmapped = !onehot_valid(MAX_SLAVES'(bus.HSEL_S));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= '0;
      def_q  <= 1'b1;
    end else if (capture) begin
      dsel_q <= bus.HSEL_S;
      def_q  <= unmapped;
    end
  end

  // With def_q=0 the select is one-hot, so OR-reduction picks a single slave.
  always_comb begin
    rdata_sel = '0;
    ready_sel = 1'b0;
    resp_sel  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        rdata_sel = rdata_sel | bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        ready_sel = ready_sel | bus.HREADYOUT_S[i];
        resp_sel  = resp_sel  | bus.HRESP_S[i];
      end
    end
  end

  assign bus.HRDATA = def_q ? '0        : rdata_sel;
  assign bus.HREADY = def_q ? ds_hready : ready_sel;
  assign bus.HRESP  = def_q ? ds_hresp  : resp_sel;

  ahb_default_slave u_default_slave (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .capture  (capture),
    .unmapped (unmapped),
    .htrans   (bus.HTRANS),
    .hready   (ds_hready),
    .hresp    (ds_hresp),
    .dec_err  (bus.DEC_ERR),
    .state    (ds_state)
  );

endmodule

// File: tb/tb_ahb_resp_mux_n.sv
// Directed bench for ahb_resp_mux_n with a per-data-phase reference model.
module tb_ahb_resp_mux_n;
  import ahb_pkg::*;

  localparam int DW = 32;
  localparam int NS = 4;

  // ---------------- clock / reset ----------------
  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_resp_mux_n_if #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();
  ds_state_t ds_state;

  logic [DW-1:0] sdata [NS];
  logic [NS-1:0] sresp;
  logic [NS-1:0] sready;

  assign bus.HRDATA_S    = {sdata[3], sdata[2], sdata[1], sdata[0]};
  assign bus.HRESP_S     = sresp;
  assign bus.HREADYOUT_S = sready;

  ahb_resp_mux_n #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .ds_state (ds_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Kind of the data phase in progress: 0 OKAY/no phase, 1 mapped slave,
  // 2 first error cycle, 3 second error cycle.
  int m_kind = 0;
  int m_idx  = 0;

  function automatic logic exp_ready();
    case (m_kind)
      1:       return sready[m_idx];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_resp();
    case (m_kind)
      1:       return sresp[m_idx];
      2, 3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_kind == 1) ? sdata[m_idx] : '0;
  endfunction

  function automatic logic exp_dec();
    return m_kind == 2;
  endfunction

  function automatic ds_state_t exp_state();
    case (m_kind)
      2:       return DS_ERR1;
      3:       return DS_ERR2;
      default: return DS_IDLE;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_kind = 0;
      m_idx  = 0;
    end else if (m_kind == 2) begin
      m_kind = 3;
    end else if (exp_ready()) begin
      if ($countones(bus.HSEL_S) == 1) begin
        m_kind = 1;
        for (int i = 0; i < NS; i++) if (bus.HSEL_S[i]) m_idx = i;
      end else if (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ) begin
        m_kind = 2;
      end else begin
        m_kind = 0;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge HCLK) begin
    check("cmp_hrdata",  bus.HRDATA,  exp_data());
    check("cmp_hready",  bus.HREADY,  exp_ready());
    check("cmp_hresp",   bus.HRESP,   exp_resp());
    check("cmp_dec_err", bus.DEC_ERR, exp_dec());
    check("cmp_state",   ds_state,    exp_state());
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr(input logic [NS-1:0] sel, input logic [1:0] trans);
    bus.HSEL_S = sel;
    bus.HTRANS = trans;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic rsp,
                            input logic dec, input logic [31:0] data);
    @(negedge HCLK);
    check({name, "_hready"},  bus.HREADY,  rdy);
    check({name, "_hresp"},   bus.HRESP,   rsp);
    check({name, "_dec_err"}, bus.DEC_ERR, dec);
    check({name, "_hrdata"},  bus.HRDATA,  data);
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] route_tab [NS];

  initial begin
    route_tab = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF, 32'h4444_4444};
    for (int i = 0; i < NS; i++) sdata[i] = route_tab[i];
    sresp  = '0;
    sready = '1;
    addr('0, HTRANS_IDLE);

    // Reset held for 3 cycles, then released with an idle bus.
    repeat (3) @(posedge HCLK);
    expect_out("reset_hold", 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    HRESETn = 1'b1;
    expect_out("reset_rel", 1'b1, 1'b0, 1'b0, 32'h0);
    check("reset_state", ds_state, DS_IDLE);

    // Routing, one slave at a time.
    for (int k = 0; k < NS; k++) begin
      next_cycle();
      addr(4'b0001 << k, HTRANS_NONSEQ);
      next_cycle();
      addr('0, HTRANS_IDLE);
      expect_out($sformatf("route%0d", k), 1'b1, 1'b0, 1'b0, route_tab[k]);
    end

    // Slave 1 inserts two wait states while the decoder already points at slave 3.
    next_cycle();
    addr(4'b0010, HTRANS_NONSEQ);
    next_cycle();
    addr(4'b1000, HTRANS_NONSEQ);
    sready[1] = 1'b0;
    sdata[1]  = 32'h5A5A_0001;
    expect_out("wait1", 1'b0, 1'b0, 1'b0, 32'h5A5A_0001);
    next_cycle();
    sdata[1] = 32'h5A5A_0002;
    sresp[1] = 1'b1;
    expect_out("wait2", 1'b0, 1'b1, 1'b0, 32'h5A5A_0002);
    next_cycle();
    sready[1] = 1'b1;
    expect_out("wait_done", 1'b1, 1'b1, 1'b0, 32'h5A5A_0002);
    next_cycle();
    sresp[1] = 1'b0;
    addr('0, HTRANS_IDLE);
    expect_out("wait_next", 1'b1, 1'b0, 1'b0, 32'h4444_4444);

    // Unmapped NONSEQ: ERROR over two cycles, then OKAY.
    next_cycle();
    addr('0, HTRANS_NONSEQ);
    next_cycle();
    addr('0, HTRANS_IDLE);
    expect_out("unmap_err1", 1'b0, 1'b1, 1'b1, 32'h0);
    check("unmap_state1", ds_state, DS_ERR1);
    next_cycle();
    expect_out("unmap_err2", 1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle();
    expect_out("unmap_done", 1'b1, 1'b0, 1'b0, 32'h0);

    // Unmapped IDLE and BUSY: zero-wait OKAY.
    next_cycle();
    addr('0, HTRANS_BUSY);
    next_cycle();
    addr('0, HTRANS_IDLE);
    expect_out("unmap_busy", 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    expect_out("unmap_idle", 1'b1, 1'b0, 1'b0, 32'h0);

    // Multi-hot select behaves as unmapped.
    next_cycle();
    addr(4'b0011, HTRANS_NONSEQ);
    next_cycle();
    addr('0, HTRANS_IDLE);
    expect_out("multi_err1", 1'b0, 1'b1, 1'b1, 32'h0);
    next_cycle();
    expect_out("multi_err2", 1'b1, 1'b1, 1'b0, 32'h0);

    // Two unmapped transfers back to back.
    next_cycle();
    addr('0, HTRANS_NONSEQ);
    next_cycle();
    addr('0, HTRANS_SEQ);
    expect_out("b2b_err1a", 1'b0, 1'b1, 1'b1, 32'h0);
    next_cycle();
    expect_out("b2b_err2a", 1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle();
    addr('0, HTRANS_IDLE);
    expect_out("b2b_err1b", 1'b0, 1'b1, 1'b1, 32'h0);
    check("b2b_state1b", ds_state, DS_ERR1);
    next_cycle();
    expect_out("b2b_err2b", 1'b1, 1'b1, 1'b0, 32'h0);
    next_cycle();
    expect_out("b2b_done", 1'b1, 1'b0, 1'b0, 32'h0);

    // Mapped followed by unmapped: error starts after the slave completes.
    addr(4'b0100, HTRANS_NONSEQ);
    next_cycle();
    addr('0, HTRANS_NONSEQ);
    expect_out("m2u_mapped", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    next_cycle();
    addr('0, HTRANS_IDLE);
    expect_out("m2u_err1", 1'b0, 1'b1, 1'b1, 32'h0);
    next_cycle();
    expect_out("m2u_err2", 1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of the first error cycle.
    next_cycle();
    addr('0, HTRANS_NONSEQ);
    next_cycle();
    addr('0, HTRANS_IDLE);
    check("areset_pre_hready", bus.HREADY, 1'b0);
    #3;
    HRESETn = 1'b0;
    #1;
    check("areset_hready",  bus.HREADY,  1'b1);
    check("areset_hresp",   bus.HRESP,   1'b0);
    check("areset_dec_err", bus.DEC_ERR, 1'b0);
    check("areset_state",   ds_state,    DS_IDLE);
    next_cycle();
    HRESETn = 1'b1;
    expect_out("areset_rel", 1'b1, 1'b0, 1'b0, 32'h0);
    check("areset_rel_state", ds_state, DS_IDLE);

    next_cycle();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
